stat_fifo_drain: RTL and testbench

//  Read-side consumer of a show-ahead status FIFO (stat_fifo_generic, SHOWAHEAD="ON", DUAL_CLOCK=0).

---
 rtl/stat_fifo_drain.sv | 137 +++++++++++++
 tb/tb_stat_fifo_drain.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_fifo_drain.sv
// Drains a show-ahead status FIFO into packet/byte/error counters and a
// max-length tracker, exposed to the CPU as snapshot copies over a 32-bit CSR slave.
module stat_fifo_drain #(
    parameter int DWIDTH = 64,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              rd_empty_i,
    input  logic [DWIDTH-1:0] rd_data_i,
    output logic              rd_req_o,
    input  logic [2:0]        csr_address_i,
    input  logic              csr_read_i,
    input  logic              csr_write_i,
    input  logic [31:0]       csr_writedata_i,
    output logic [31:0]       csr_readdata_o
);

    localparam int NCNT = 3;  // 0: packets, 1: bytes, 2: errored packets

    logic                       stage_valid_reg;
    logic [LEN_W+2:0]           stage_data_reg;
    logic [LEN_W-1:0]           stage_len;
    logic                       stage_err;
    logic                       snapshot;
    logic                       clear;
    logic [NCNT-1:0][CNT_W-1:0] cnt_inc;
    logic [NCNT-1:0][63:0]      shadow_ext;
    logic [LEN_W-1:0]           max_len_reg;
    logic [LEN_W-1:0]           max_len_next;
    logic [LEN_W-1:0]           max_shadow_reg;
    logic [31:0]                rd_mux;
    logic                       unused_bits;

    assign rd_req_o  = en_i & ~rd_empty_i & rst_n_i;
    assign snapshot  = csr_write_i & csr_writedata_i[0];
    assign clear     = csr_write_i & csr_writedata_i[1];
    assign stage_len = stage_data_reg[LEN_W-1:0];
    assign stage_err = |stage_data_reg[LEN_W+2:LEN_W];

    assign cnt_inc[0] = CNT_W'(1);
    assign cnt_inc[1] = CNT_W'(stage_len);
    assign cnt_inc[2] = CNT_W'(stage_err);

    // Status bits above the flags and CTRL bits above clear carry no meaning.
    assign unused_bits = ^{rd_data_i, csr_writedata_i};

    // Only the length and the three flag bits are needed once a word is popped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= '0;
        end else begin
            stage_valid_reg <= rd_req_o;
            if (rd_req_o) begin
                stage_data_reg <= rd_data_i[LEN_W+2:0];
            end
        end
    end

    // Clear zeroes the base value; a concurrent pipeline update still lands on top.
    // The shadow samples the pre-edge counter, so snapshot always precedes clear.
    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] shadow_reg;

            always_comb begin
                cnt_next = clear ? '0 : cnt_reg;
                if (stage_valid_reg) begin
                    cnt_next = cnt_next + cnt_inc[gi];
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    cnt_reg    <= '0;
                    shadow_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                    if (snapshot) begin
                        shadow_reg <= cnt_reg;
                    end
                end
            end

            assign shadow_ext[gi] = 64'(shadow_reg);
        end
    endgenerate

    always_comb begin
        max_len_next = clear ? '0 : max_len_reg;
        if (stage_valid_reg && (stage_len > max_len_next)) begin
            max_len_next = stage_len;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            max_len_reg    <= '0;
            max_shadow_reg <= '0;
        end else begin
            max_len_reg <= max_len_next;
            if (snapshot) begin
                max_shadow_reg <= max_len_reg;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address_i)
            3'd0: rd_mux = {30'b0, stage_valid_reg, en_i};
            3'd1: rd_mux = shadow_ext[0][31:0];
            3'd2: rd_mux = shadow_ext[0][63:32];
            3'd3: rd_mux = shadow_ext[1][31:0];
            3'd4: rd_mux = shadow_ext[1][63:32];
            3'd5: rd_mux = shadow_ext[2][31:0];
            3'd6: rd_mux = shadow_ext[2][63:32];
            3'd7: rd_mux = 32'(max_shadow_reg);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            csr_readdata_o <= '0;
        end else if (csr_read_i) begin
            csr_readdata_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_stat_fifo_drain.sv
// Randomised and directed bench for stat_fifo_drain: a queue-based FIFO and
// counter scoreboard predict every CSR read and every pop request.
module tb_stat_fifo_drain;

    logic        clk;
    logic        rst_n_i;
    logic        en_i;
    logic        rd_empty_i;
    logic [63:0] rd_data_i;
    logic        rd_req_o;
    logic [2:0]  csr_address_i;
    logic        csr_read_i;
    logic        csr_write_i;
    logic [31:0] csr_writedata_i;
    logic [31:0] csr_readdata_o;

    // second instance with a wide length field so the 33-bit wrap is reachable quickly
    logic        w_en;
    logic        w_empty;
    logic [63:0] w_data;
    logic        w_rd_req;
    logic [2:0]  w_addr;
    logic        w_read;
    logic        w_write;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    stat_fifo_drain #(.DWIDTH(64), .LEN_W(16), .CNT_W(64)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .en_i(en_i), .rd_empty_i(rd_empty_i),
        .rd_data_i(rd_data_i), .rd_req_o(rd_req_o), .csr_address_i(csr_address_i),
        .csr_read_i(csr_read_i), .csr_write_i(csr_write_i),
        .csr_writedata_i(csr_writedata_i), .csr_readdata_o(csr_readdata_o)
    );

    stat_fifo_drain #(.DWIDTH(64), .LEN_W(28), .CNT_W(33)) u_wrap (
        .clk_i(clk), .rst_n_i(rst_n_i), .en_i(w_en), .rd_empty_i(w_empty),
        .rd_data_i(w_data), .rd_req_o(w_rd_req), .csr_address_i(w_addr),
        .csr_read_i(w_read), .csr_write_i(w_write),
        .csr_writedata_i(w_wdata), .csr_readdata_o(w_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;
    int cycle    = 0;

    // reference state: FIFO contents, totals, shadows, in-flight word
    logic [63:0]     fifo_q[$];
    longint unsigned m_cnt[3];
    longint unsigned m_sh[3];
    int unsigned     m_max;
    int unsigned     m_sh_max;
    bit              m_pend;
    logic [63:0]     m_pend_word;
    logic [31:0]     exp_rd = '0;
    int              pop_cyc[$];

    longint unsigned tot_pkt;
    longint unsigned tot_bytes;
    longint unsigned tot_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] csr_view(input logic [2:0] a);
        logic [63:0] v;
        int idx;
        if (a == 3'd0) return {30'b0, m_pend, en_i};
        if (a == 3'd7) return m_sh_max;
        idx = (int'(a) - 1) / 2;
        v = m_sh[idx];
        return a[0] ? v[31:0] : v[63:32];
    endfunction

    // Reference update at every active edge using the pre-edge inputs.
    always @(posedge clk) begin : model
        bit          pop;
        logic [15:0] plen;
        cycle++;
        if (!rst_n_i) begin
            foreach (m_cnt[k]) begin
                m_cnt[k] = 0;
                m_sh[k]  = 0;
            end
            m_max = 0; m_sh_max = 0; m_pend = 0; exp_rd = '0;
        end else begin
            pop = en_i && (fifo_q.size() > 0);
            if (csr_read_i) exp_rd = csr_view(csr_address_i);
            if (csr_write_i && csr_writedata_i[0]) begin
                m_sh = m_cnt;
                m_sh_max = m_max;
            end
            if (csr_write_i && csr_writedata_i[1]) begin
                foreach (m_cnt[k]) m_cnt[k] = 0;
                m_max = 0;
            end
            if (m_pend) begin
                plen = m_pend_word[15:0];
                m_cnt[0] += 1;
                m_cnt[1] += plen;
                if (m_pend_word[18:16] != 3'b000) m_cnt[2] += 1;
                if (plen > m_max) m_max = plen;
            end
            m_pend = pop;
            if (pop) begin
                m_pend_word = fifo_q.pop_front();
                pop_cyc.push_back(cycle);
            end
        end
    end

    // Compare process: CSR data on every negedge, pop request shortly after.
    always @(negedge clk) begin
        if (armed) begin
            chk("csr_readdata", csr_readdata_o, exp_rd);
            #2;
            chk("rd_req", rd_req_o, rst_n_i && en_i && (fifo_q.size() > 0));
            if (rd_req_o && rd_empty_i) begin
                failures++;
                $display("FAIL pop_on_empty: rd_req_o=1 while rd_empty_i=1 (t=%0t)", $time);
            end
        end
    end

    task automatic present();
        rd_empty_i = (fifo_q.size() == 0);
        rd_data_i  = rd_empty_i ? {$urandom, $urandom} : fifo_q[0];
    endtask

    task automatic cyc();
        present();
        @(negedge clk);
    endtask

    task automatic push_word(input int unsigned len, input bit [2:0] flags);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[15:0]  = len[15:0];
        w[18:16] = flags;
        fifo_q.push_back(w);
        tot_pkt++;
        tot_bytes += len[15:0];
        if (flags != 3'b000) tot_err++;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address_i = a;
        csr_read_i    = 1'b1;
        cyc();
        csr_read_i    = 1'b0;
        d = csr_readdata_o;
    endtask

    task automatic rd64(input logic [2:0] a, output logic [63:0] v);
        logic [31:0] lo, hi;
        csr_rd(a, lo);
        csr_rd(a + 3'd1, hi);
        v = {hi, lo};
    endtask

    task automatic csr_wr(input logic [31:0] d);
        csr_writedata_i = d;
        csr_write_i     = 1'b1;
        cyc();
        csr_write_i     = 1'b0;
    endtask

    task automatic reset_totals();
        tot_pkt = 0; tot_bytes = 0; tot_err = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || m_pend) && n < 500) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles", fifo_q.size(), n);
        end
        cyc();
    endtask

    task automatic w_rd(input logic [2:0] a, output logic [31:0] d);
        w_addr = a;
        w_read = 1'b1;
        cyc();
        w_read = 1'b0;
        d = w_rdata;
    endtask

    task automatic w_snapshot();
        w_wdata = 32'd1;
        w_write = 1'b1;
        cyc();
        w_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] d;
        logic [63:0] v, sh_pkt, sh_bytes, fin_pkt, fin_bytes, a_pkt, b_pkt;
        longint unsigned e;
        longint unsigned wlen;

        rst_n_i = 1'b0; en_i = 1'b0; csr_address_i = '0; csr_read_i = 1'b0;
        csr_write_i = 1'b0; csr_writedata_i = '0;
        w_en = 1'b0; w_empty = 1'b1; w_data = '0; w_addr = '0; w_read = 1'b0;
        w_write = 1'b0; w_wdata = '0;
        reset_totals();
        present();
        @(negedge clk);

        // T1: reset held with words queued and drain enabled
        push_word(100, 0); push_word(200, 0); push_word(300, 1);
        en_i = 1'b1;
        cyc();
        armed = 1;
        repeat (3) cyc();
        chk("t1_rdreq_in_reset", rd_req_o, 1'b0);
        rst_n_i = 1'b1;
        en_i = 1'b0;
        cyc();
        for (int a = 0; a < 8; a++) begin
            csr_rd(3'(a), d);
            chk($sformatf("t1_csr%0d_zero", a), d, 32'd0);
        end
        fifo_q.delete();
        reset_totals();

        // T2: burst of four clean words drained back to back
        pop_cyc.delete();
        push_word(64, 0); push_word(128, 0); push_word(1518, 0); push_word(60, 0);
        en_i = 1'b1;
        wait_drain();
        chk("t2_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) chk("t2_pops_consecutive", pop_cyc[3] - pop_cyc[0], 3);
        csr_wr(32'd1);
        csr_rd(3'd1, d); chk("t2_pkt", d, 32'd4);
        csr_rd(3'd3, d); chk("t2_bytes", d, 32'd1770);
        csr_rd(3'd5, d); chk("t2_err", d, 32'd0);
        csr_rd(3'd7, d); chk("t2_max", d, 32'd1518);
        csr_rd(3'd2, d); chk("t2_pkt_hi", d, 32'd0);

        // T3: error flags
        csr_wr(32'd2);
        push_word(60, 3'b001); push_word(40, 3'b010); push_word(100, 3'b000);
        wait_drain();
        csr_wr(32'd1);
        csr_rd(3'd1, d); chk("t3_pkt", d, 32'd3);
        csr_rd(3'd5, d); chk("t3_err", d, 32'd2);
        csr_rd(3'd3, d); chk("t3_bytes", d, 32'd200);
        csr_rd(3'd7, d); chk("t3_max", d, 32'd100);

        // T4: snapshot+clear while streaming one word per cycle
        csr_wr(32'd2);
        reset_totals();
        for (int i = 0; i < 30; i++) push_word($urandom_range(0, 65535), 3'($urandom_range(0, 7)));
        repeat (10) cyc();
        csr_wr(32'd3);
        rd64(3'd1, sh_pkt);
        rd64(3'd3, sh_bytes);
        wait_drain();
        csr_wr(32'd1);
        rd64(3'd1, fin_pkt);
        rd64(3'd3, fin_bytes);
        chk("t4_pkt_sum", sh_pkt + fin_pkt, tot_pkt);
        chk("t4_byte_sum", sh_bytes + fin_bytes, tot_bytes);

        // T6: drain paused with a non-empty FIFO
        csr_wr(32'd2);
        reset_totals();
        for (int i = 0; i < 20; i++) push_word($urandom_range(0, 9000), 3'($urandom_range(0, 7)));
        repeat (3) cyc();
        en_i = 1'b0;
        repeat (2) cyc();
        csr_wr(32'd1);
        rd64(3'd1, a_pkt);
        chk("t6_inflight_done", a_pkt, 64'd3);
        repeat (6) begin
            cyc();
            chk("t6_paused_rdreq", rd_req_o, 1'b0);
        end
        csr_wr(32'd1);
        rd64(3'd1, b_pkt);
        chk("t6_frozen", b_pkt, a_pkt);
        en_i = 1'b1;
        wait_drain();
        csr_wr(32'd1);
        rd64(3'd1, v); chk("t6_total_pkt", v, tot_pkt);
        rd64(3'd3, v); chk("t6_total_bytes", v, tot_bytes);
        rd64(3'd5, v); chk("t6_total_err", v, tot_err);

        // Random phase: pushes, enable toggles, CSR traffic, one reset pulse
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) push_word($urandom_range(0, 65535), 3'($urandom_range(0, 7)));
            en_i            = ($urandom_range(0, 7) != 0);
            csr_read_i      = 1'($urandom_range(0, 1));
            csr_address_i   = 3'($urandom_range(0, 7));
            csr_write_i     = ($urandom_range(0, 15) == 0);
            csr_writedata_i = $urandom;
            rst_n_i         = (i != 150);
            cyc();
        end
        rst_n_i = 1'b1; csr_read_i = 1'b0; csr_write_i = 1'b0; en_i = 1'b1;
        wait_drain();
        csr_wr(32'd1);
        for (int a = 0; a < 8; a++) csr_rd(3'(a), d);

        // T5: 33-bit byte counter wrap on the wide-length instance
        wlen = (64'd1 << 28) - 1;
        w_data = '0;
        w_data[27:0] = '1;
        w_en = 1'b1;
        w_empty = 1'b0;
        repeat (20) cyc();
        w_empty = 1'b1;
        repeat (3) cyc();
        w_snapshot();
        e = (20 * wlen) % (64'd1 << 33);
        w_rd(3'd1, d); chk("t5_pkt20", d, 32'd20);
        w_rd(3'd3, d); chk("t5_lo20", d, e[31:0]);
        w_rd(3'd4, d); chk("t5_hi20", d, 32'd1);
        w_empty = 1'b0;
        repeat (20) cyc();
        w_empty = 1'b1;
        repeat (3) cyc();
        w_snapshot();
        e = (40 * wlen) % (64'd1 << 33);
        w_rd(3'd1, d); chk("t5_pkt40", d, 32'd40);
        w_rd(3'd3, d); chk("t5_lo40", d, e[31:0]);
        w_rd(3'd4, d); chk("t5_hi40_wrapped", d, 32'd0);
        w_rd(3'd7, d); chk("t5_max", d, wlen[31:0]);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
